// File: rtl/coproc_issue_pkg.sv
// Shared definitions for the coprocessor issue front end: opcodes,
// instruction field positions and FSM state encodings.
package coproc_issue_pkg;

    localparam logic [3:0] OP_SIG0    = 4'd0;
    localparam logic [3:0] OP_SIG1    = 4'd1;
    localparam logic [3:0] OP_SUM0    = 4'd2;
    localparam logic [3:0] OP_SUM1    = 4'd3;
    localparam logic [3:0] OP_D_MID   = 4'd4;
    localparam logic [3:0] OP_D_FINAL = 4'd5;
    localparam logic [3:0] OP_E_MID   = 4'd6;
    localparam logic [3:0] OP_E_FINAL = 4'd7;
    localparam logic [3:0] OP_LLI     = 4'd8;
    localparam logic [3:0] OP_LUI     = 4'd9;
    localparam logic [3:0] OP_NOP     = 4'hF;

    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned RD_LSB  = 24;
    localparam int unsigned RS1_LSB = 20;
    localparam int unsigned RS2_LSB = 16;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_LUI;
    endfunction

endpackage

// File: rtl/regfile_16x32.sv
// 16x32 register file: one synchronous write port, two combinational
// operand reads and a registered host read port, cleared on reset.
module regfile_16x32 #(
    parameter int unsigned NREGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [3:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic [3:0]  host_raddr,
    output logic [31:0] host_rdata
);

    logic [31:0] mem [NREGS];

    // Host read samples the array before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            host_rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            host_rdata <= mem[host_raddr];
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/coproc_issue.sv
// Coprocessor issue front end: host handshake, decode, operand fetch,
// compute-unit sequencing and writeback, one instruction at a time.
module coproc_issue
    import coproc_issue_pkg::*;
#(
    parameter int unsigned CU_LAT = 0,
    parameter int unsigned NREGS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  cu_operation,
    output logic [31:0] cu_rs1,
    output logic [31:0] cu_rs2,
    output logic [15:0] cu_imm,
    input  logic [31:0] cu_result,
    output logic        done,
    output logic        err,
    output logic        busy,
    input  logic [3:0]  reg_raddr,
    output logic [31:0] reg_rdata
);

    localparam int unsigned CNT_W = (CU_LAT > 0) ? $clog2(CU_LAT + 1) : 1;

    state_t           state, state_nxt;
    logic [31:0]      instr_q, result_q, rf_rdata_a, rf_rdata_b;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q, rd_q, rs1_q, rs2_q;
    logic [15:0]      imm_q;
    logic             legal, is_aes, is_load, rf_we;

    assign op_q    = instr_q[OPC_LSB +: 4];
    assign rd_q    = instr_q[RD_LSB +: 4];
    assign rs1_q   = instr_q[RS1_LSB +: 4];
    assign rs2_q   = instr_q[RS2_LSB +: 4];
    assign imm_q   = instr_q[IMM_LSB +: 16];
    assign legal   = is_legal(op_q);
    assign is_aes  = (op_q >= OP_D_MID) && (op_q <= OP_E_FINAL);
    assign is_load = (op_q == OP_LLI) || (op_q == OP_LUI);

    // Loads read the old rd so the compute unit can merge the half-word.
    regfile_16x32 #(.NREGS(NREGS)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we         (rf_we),
        .waddr      (rd_q),
        .wdata      (result_q),
        .raddr_a    (is_load ? rd_q : rs1_q),
        .rdata_a    (rf_rdata_a),
        .raddr_b    (rs2_q),
        .rdata_b    (rf_rdata_b),
        .host_raddr (reg_raddr),
        .host_rdata (reg_rdata)
    );

    always_comb begin
        state_nxt    = state;
        instr_ready  = 1'b0;
        cu_operation = OP_NOP;
        rf_we        = 1'b0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = ST_READ;
            end
            ST_READ: state_nxt = legal ? ST_EXEC : ST_IDLE;
            ST_EXEC: begin
                cu_operation = op_q;
                if (cnt == '0) state_nxt = ST_WB;
            end
            ST_WB: begin
                rf_we     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            instr_q  <= '0;
            cu_rs1   <= '0;
            cu_rs2   <= '0;
            cu_imm   <= '0;
            result_q <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == ST_WB) || ((state == ST_READ) && !legal);
            case (state)
                ST_IDLE: if (instr_valid) instr_q <= instr;
                ST_READ: begin
                    if (legal) begin
                        cu_rs1 <= rf_rdata_a;
                        cu_rs2 <= is_aes ? rf_rdata_b : (is_load ? {16'h0, imm_q} : '0);
                        cu_imm <= imm_q;
                        cnt    <= CNT_W'(CU_LAT);
                    end else begin
                        err <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) result_q <= cu_result;
                    else           cnt      <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
